// File: rtl/risco5_wb_bridge.sv
// Risco-5 native memory port to Wishbone-classic master bridge.
// Handles byte selects, lane steering, alignment checks and an ack timeout.
module risco5_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit PIPE_RESP      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [1:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_response,
  output logic        bus_error,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_WAIT_DROP} state_t;

  state_t            r_state;
  logic              r_decode;
  logic              r_we;
  logic [1:0]        r_opt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pend_err;
  logic              r_pend_upd;
  logic [31:0]       r_pend_rdata;

  logic              w_misaligned;
  logic              w_timeout;
  logic [3:0]        w_sel;
  logic [31:0]       w_wlane;
  logic [31:0]       w_rd_shift;
  logic [31:0]       w_rd_sized;
  logic              w_fin;
  logic              w_fin_err;
  logic              w_fin_upd;
  logic [31:0]       w_fin_rdata;

  // Option 11 is treated as a word access everywhere below.
  assign w_misaligned = ((r_opt == 2'b01) && r_addr[0]) ||
                        (r_opt[1] && (r_addr[1:0] != 2'b00));
  assign w_timeout    = (r_cnt == C_TMAX);
  assign w_rd_shift   = wb_data_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_opt)
      2'b00: begin
        w_sel      = 4'b0001 << r_addr[1:0];
        w_wlane    = {4{r_wdata[7:0]}};
        w_rd_sized = {24'h0, w_rd_shift[7:0]};
      end
      2'b01: begin
        w_sel      = 4'b0011 << r_addr[1:0];
        w_wlane    = {2{r_wdata[15:0]}};
        w_rd_sized = {16'h0, w_rd_shift[15:0]};
      end
      default: begin
        w_sel      = 4'b1111;
        w_wlane    = r_wdata;
        w_rd_sized = w_rd_shift;
      end
    endcase
  end

  // Transaction completion: misaligned reject, slave ack (wins over timeout), or timeout.
  always_comb begin
    w_fin       = 1'b0;
    w_fin_err   = 1'b0;
    w_fin_upd   = 1'b0;
    w_fin_rdata = 32'h0;
    if (r_state == S_IDLE && r_decode && w_misaligned) begin
      w_fin     = 1'b1;
      w_fin_err = 1'b1;
    end else if (r_state == S_BUS) begin
      if (wb_ack) begin
        w_fin       = 1'b1;
        w_fin_upd   = !r_we;
        w_fin_rdata = w_rd_sized;
      end else if (w_timeout) begin
        w_fin     = 1'b1;
        w_fin_err = 1'b1;
        w_fin_upd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_decode        <= 1'b0;
      r_we            <= 1'b0;
      r_opt           <= 2'b00;
      r_addr          <= 32'h0;
      r_wdata         <= 32'h0;
      r_cnt           <= '0;
      r_pend_err      <= 1'b0;
      r_pend_upd      <= 1'b0;
      r_pend_rdata    <= 32'h0;
      read_data       <= 32'h0;
      memory_response <= 1'b0;
      bus_error       <= 1'b0;
      wb_cyc          <= 1'b0;
      wb_stb          <= 1'b0;
      wb_we           <= 1'b0;
      wb_sel          <= 4'h0;
      wb_addr         <= 32'h0;
      wb_data_o       <= 32'h0;
    end else begin
      memory_response <= 1'b0;
      bus_error       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_decode) begin
            r_decode <= 1'b0;
            if (!w_misaligned) begin
              wb_cyc    <= 1'b1;
              wb_stb    <= 1'b1;
              wb_we     <= r_we;
              wb_sel    <= w_sel;
              wb_addr   <= {r_addr[31:2], 2'b00};
              wb_data_o <= w_wlane;
              r_cnt     <= '0;
              r_state   <= S_BUS;
            end
          end else if (memory_read || memory_write) begin
            r_decode <= 1'b1;
            r_we     <= memory_write;
            r_opt    <= option;
            r_addr   <= address;
            r_wdata  <= write_data;
          end
        end
        S_BUS: begin
          if (wb_ack || w_timeout) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            wb_sel <= 4'h0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (PIPE_RESP) begin
            memory_response <= 1'b1;
            bus_error       <= r_pend_err;
            if (r_pend_upd) read_data <= r_pend_rdata;
          end
          r_state <= S_WAIT_DROP;
        end
        S_WAIT_DROP: begin
          // A request still held from the finished transaction must not reissue.
          if (!memory_read && !memory_write) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_fin) begin
        if (!PIPE_RESP) begin
          memory_response <= 1'b1;
          bus_error       <= w_fin_err;
          if (w_fin_upd) read_data <= w_fin_rdata;
        end else begin
          r_pend_err   <= w_fin_err;
          r_pend_upd   <= w_fin_upd;
          r_pend_rdata <= w_fin_rdata;
        end
        r_state <= S_RESP;
      end
    end
  end

endmodule

// File: tb/tb_risco5_wb_bridge.sv
// Self-checking bench for risco5_wb_bridge: vector table, hand sequences and
// randomized transactions against a transaction-level reference model.
module tb_risco5_wb_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [1:0]  option = 2'b00;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        memory_response;
  logic        bus_error;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i = 32'h0;
  logic        wb_ack = 1'b0;

  always #5 clk = ~clk;

  risco5_wb_bridge #(.TIMEOUT_CYCLES(TMO), .PIPE_RESP(1'b0)) dut (
    .clk(clk), .reset(reset),
    .memory_read(memory_read), .memory_write(memory_write),
    .option(option), .address(address), .write_data(write_data),
    .read_data(read_data), .memory_response(memory_response), .bus_error(bus_error),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_addr(wb_addr), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack(wb_ack)
  );

  int total = 0;
  int bad = 0;
  int txn_id = 0;
  logic [31:0] model_rd = 32'h0;

  // Observations of the last transaction
  logic [3:0]  g_sel;
  logic [31:0] g_addr, g_dout, g_rdata;
  logic        g_we, g_err;
  int          g_cyc, g_lat, g_resp, g_extra, g_unstable;

  typedef struct {
    logic        we;
    logic [1:0]  opt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] srd;
    int          waits;
    int          ecyc;
    logic [3:0]  esel;
    logic [31:0] eaddr;
    logic [31:0] edout;
    logic [31:0] erd;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, got, exp);
    end
  endtask

  // Drives one core request and plays a slave that acks after `waits` cyc cycles.
  task automatic run_txn(input logic we, input logic both, input logic [1:0] opt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] srd, input int waits, input int hold,
                         input logic drop);
    g_sel = 4'h0; g_addr = 32'h0; g_dout = 32'h0; g_rdata = 32'h0;
    g_we = 1'b0; g_err = 1'b0;
    g_cyc = 0; g_lat = -1; g_resp = 0; g_extra = 0; g_unstable = 0;
    @(negedge clk);
    memory_write = we;
    memory_read  = !we || both;
    option       = opt;
    address      = addr;
    write_data   = wdata;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (memory_response) begin
        g_resp++;
        g_rdata = read_data;
        g_err   = bus_error;
        g_lat   = c;
        wb_ack  = 1'b0;
        break;
      end
      if (wb_cyc) begin
        g_cyc++;
        if (g_cyc == 1) begin
          g_sel = wb_sel; g_addr = wb_addr; g_dout = wb_data_o; g_we = wb_we;
        end else if (wb_sel !== g_sel || wb_addr !== g_addr || wb_data_o !== g_dout ||
                     wb_we !== g_we || wb_stb !== 1'b1) begin
          g_unstable++;
        end
        if (drop) begin
          memory_read = 1'b0;
          memory_write = 1'b0;
        end
        if (g_cyc == waits + 1) begin
          wb_ack = 1'b1; wb_data_i = srd;
        end else begin
          wb_ack = 1'b0; wb_data_i = $urandom;
        end
      end else begin
        wb_ack = 1'b0;
      end
    end
    for (int h = 0; h < hold + 3; h++) begin
      if (h == hold) begin
        memory_read = 1'b0;
        memory_write = 1'b0;
      end
      @(negedge clk);
      if (wb_cyc) g_extra++;
      if (memory_response) g_resp++;
    end
  endtask

  task automatic check_txn(input logic ewe, input int ecyc, input logic [3:0] esel,
                           input logic [31:0] eaddr, input logic [31:0] edout,
                           input logic [31:0] erd, input logic eerr, input int elat);
    $display("txn %0d: addr=%h cyc=%0d sel=%b dout=%h rdata=%h err=%0d lat=%0d",
             txn_id, address, g_cyc, g_sel, g_dout, g_rdata, g_err, g_lat);
    chk($sformatf("t%0d_cyc_cycles", txn_id), g_cyc, ecyc);
    chk($sformatf("t%0d_latency", txn_id), g_lat, elat);
    chk($sformatf("t%0d_bus_error", txn_id), {31'h0, g_err}, {31'h0, eerr});
    chk($sformatf("t%0d_read_data", txn_id), g_rdata, erd);
    chk($sformatf("t%0d_resp_count", txn_id), g_resp, 1);
    chk($sformatf("t%0d_extra_cyc", txn_id), g_extra, 0);
    if (ecyc > 0) begin
      chk($sformatf("t%0d_sel", txn_id), {28'h0, g_sel}, {28'h0, esel});
      chk($sformatf("t%0d_addr", txn_id), g_addr, eaddr);
      chk($sformatf("t%0d_we", txn_id), {31'h0, g_we}, {31'h0, ewe});
      if (ewe) chk($sformatf("t%0d_wdata", txn_id), g_dout, edout);
      chk($sformatf("t%0d_stable", txn_id), g_unstable, 0);
    end
    txn_id++;
  endtask

  // Reference model: derives the expected outcome straight from the access rules.
  task automatic model_txn(input logic we, input logic [1:0] opt, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] srd, input int waits);
    int nbytes, off, ecyc, elat;
    logic [31:0] erd, edout;
    logic [3:0] esel;
    logic eerr;
    off    = int'(addr % 4);
    nbytes = (opt == 2'b00) ? 1 : (opt == 2'b01) ? 2 : 4;
    esel   = 4'((2 ** nbytes - 1) * (2 ** off));
    if (nbytes == 1)      edout = wdata[7:0] * 32'h0101_0101;
    else if (nbytes == 2) edout = wdata[15:0] * 32'h0001_0001;
    else                  edout = wdata;
    if (off % nbytes != 0) begin
      ecyc = 0; elat = 2; eerr = 1'b1; erd = model_rd;
    end else if (waits >= TMO) begin
      ecyc = TMO; elat = TMO + 2; eerr = 1'b1; erd = 32'h0; model_rd = 32'h0;
    end else begin
      ecyc = waits + 1; elat = waits + 3; eerr = 1'b0;
      if (we) erd = model_rd;
      else begin
        erd = (srd / (2 ** (8 * off))) % (nbytes == 4 ? 33'h1_0000_0000 : 33'(2 ** (8 * nbytes)));
        model_rd = erd;
      end
    end
    check_txn(we, ecyc, esel, addr & 32'hFFFF_FFFC, edout, erd, eerr, elat);
  endtask

  initial begin
    int seen, cnt_resp, cnt_cyc;
    logic rwe;
    logic [1:0] ropt;
    logic [31:0] raddr;
    int rwaits;

    tbl[0]  = '{1'b1, 2'b10, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 2, 3, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1'b0, 5};
    tbl[1]  = '{1'b0, 2'b00, 32'h0000_2003, 32'h0, 32'hA1B2_C3D4, 0, 1, 4'b1000, 32'h0000_2000, 32'h0, 32'h0000_00A1, 1'b0, 3};
    tbl[2]  = '{1'b1, 2'b01, 32'h0000_3002, 32'h0000_5A5A, 32'h0, 1, 2, 4'b1100, 32'h0000_3000, 32'h5A5A_5A5A, 32'h0000_00A1, 1'b0, 4};
    tbl[3]  = '{1'b0, 2'b01, 32'h0000_3001, 32'h0, 32'hFFFF_FFFF, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0000_00A1, 1'b1, 2};
    tbl[4]  = '{1'b0, 2'b01, 32'h0000_4002, 32'h0, 32'h1234_5678, 0, 1, 4'b1100, 32'h0000_4000, 32'h0, 32'h0000_1234, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'b10, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 3, 4, 4'b1111, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 1'b0, 6};
    tbl[6]  = '{1'b1, 2'b00, 32'h0000_6001, 32'hFFFF_FF7E, 32'h0, 0, 1, 4'b0010, 32'h0000_6000, 32'h7E7E_7E7E, 32'hCAFE_F00D, 1'b0, 3};
    tbl[7]  = '{1'b0, 2'b11, 32'h0000_7000, 32'h0, 32'h0102_0304, 0, 1, 4'b1111, 32'h0000_7000, 32'h0, 32'h0102_0304, 1'b0, 3};
    tbl[8]  = '{1'b0, 2'b10, 32'h0000_8000, 32'h0, 32'h9999_9999, 100, TMO, 4'b1111, 32'h0000_8000, 32'h0, 32'h0, 1'b1, TMO + 2};
    tbl[9]  = '{1'b0, 2'b10, 32'h0000_9002, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, 2};
    tbl[10] = '{1'b0, 2'b00, 32'h0000_A000, 32'h0, 32'h1122_3344, 0, 1, 4'b0001, 32'h0000_A000, 32'h0, 32'h0000_0044, 1'b0, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    chk("reset_sel_we", {27'h0, wb_sel, wb_we}, 32'h0);
    chk("reset_addr", wb_addr, 32'h0);
    chk("reset_wdata", wb_data_o, 32'h0);
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_resp_err", {30'h0, memory_response, bus_error}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].we, 1'b0, tbl[i].opt, tbl[i].addr, tbl[i].wdata, tbl[i].srd,
              tbl[i].waits, 0, 1'b0);
      check_txn(tbl[i].we, tbl[i].ecyc, tbl[i].esel, tbl[i].eaddr, tbl[i].edout,
                tbl[i].erd, tbl[i].eerr, tbl[i].elat);
      model_rd = tbl[i].erd;
    end

    // Request held after response, then a normal request right after release
    run_txn(1'b0, 1'b0, 2'b10, 32'h0000_C000, 32'h0, 32'h55AA_55AA, 1, 6, 1'b0);
    model_txn(1'b0, 2'b10, 32'h0000_C000, 32'h0, 32'h55AA_55AA, 1);
    run_txn(1'b0, 1'b0, 2'b00, 32'h0000_C002, 32'h0, 32'h00BB_0000, 0, 0, 1'b0);
    model_txn(1'b0, 2'b00, 32'h0000_C002, 32'h0, 32'h00BB_0000, 0);

    // Write and read both high (write wins), request dropped mid-bus
    run_txn(1'b1, 1'b1, 2'b10, 32'h0000_D000, 32'h1357_2468, 32'h0, 2, 0, 1'b1);
    model_txn(1'b1, 2'b10, 32'h0000_D000, 32'h1357_2468, 32'h0, 2);

    for (int r = 0; r < 40; r++) begin
      rwe    = 1'($urandom % 2);
      ropt   = 2'($urandom % 4);
      raddr  = {$urandom} & 32'h000F_FFFF;
      rwaits = ($urandom % 8 == 0) ? TMO + int'($urandom % 3) : int'($urandom % 4);
      run_txn(rwe, 1'($urandom % 2), ropt, raddr, $urandom, $urandom, rwaits, int'($urandom % 3), 1'b0);
      model_txn(rwe, ropt, raddr, write_data, wb_data_i_last(), rwaits);
    end

    // Asynchronous reset mid-bus; late ack must be ignored
    @(negedge clk);
    memory_read = 1'b1; option = 2'b10; address = 32'h0000_E000;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wb_cyc) begin
        seen = 1;
        break;
      end
    end
    chk("rst_mid_cyc_seen", seen, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    chk("rst_mid_outputs", {25'h0, wb_we, |wb_sel, |wb_addr, |wb_data_o, |read_data,
                            memory_response, bus_error}, 32'h0);
    memory_read = 1'b0;
    wb_ack = 1'b1;
    wb_data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b0;
    cnt_resp = 0; cnt_cyc = 0;
    repeat (5) begin
      @(negedge clk);
      if (memory_response) cnt_resp++;
      if (wb_cyc) cnt_cyc++;
    end
    chk("rst_mid_late_ack_resp", cnt_resp, 0);
    chk("rst_mid_late_ack_cyc", cnt_cyc, 0);
    wb_ack = 1'b0;
    model_rd = 32'h0;

    run_txn(1'b0, 1'b0, 2'b01, 32'h0000_F002, 32'h0, 32'hBEEF_0000, 1, 0, 1'b0);
    model_txn(1'b0, 2'b01, 32'h0000_F002, 32'h0, 32'hBEEF_0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Slave read data presented with the ack of the last random transaction.
  logic [31:0] last_ack_data = 32'h0;
  always @(posedge clk) if (wb_ack && wb_cyc) last_ack_data <= wb_data_i;

  function automatic logic [31:0] wb_data_i_last();
    return last_ack_data;
  endfunction

endmodule

// File: doc/risco5_wb_bridge.md
Name: risco5_wb_bridge

Overview:
- Sequences memory requests from the Risco-5 core's native interface (memory_read / memory_write / option / memory_response) onto one Wishbone-classic master port.
- Generates byte selects and aligns write and read data lanes.
- Guards each transaction with an ack timeout.
- Sits between the core and the processorci_top bus (core_cyc/stb/we/sel/addr/data); one instance per memory port.

Parameters:
TIMEOUT_CYCLES, 1024, cycles with cyc high and no ack before the transaction is aborted (>=2)
PIPE_RESP, 0, 1 = register memory_response/read_data one extra cycle; 0 = respond in the cycle after ack

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
memory_read  in  1  core read request, level, held until memory_response
memory_write  in  1  core write request, level, held until memory_response
option  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
address  in  32  byte address
write_data  in  32  store data, LSB-justified
read_data  out  32  load data, LSB-justified, zero-extended
memory_response  out  1  one-cycle completion pulse
bus_error  out  1  one-cycle pulse alongside memory_response on timeout or misalignment
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  Wishbone write enable
wb_sel  out  4  byte selects
wb_addr  out  32  word-aligned address (address[1:0] forced to 0)
wb_data_o  out  32  lane-aligned write data
wb_data_i  in  32  read data from slave
wb_ack  in  1  slave acknowledge

Behaviour:
- Reset (async, immediate): state IDLE. wb_cyc=0, wb_stb=0, wb_we=0, wb_sel=0, wb_addr=0, wb_data_o=0, read_data=0, memory_response=0, bus_error=0, timeout counter=0.
- States: IDLE, BUS, RESP, WAIT_DROP.
- IDLE:
  - On memory_read or memory_write, latch address, option, write_data and we (write takes priority if both are high).
  - Check alignment: half needs address[0]=0; word needs address[1:0]=0.
  - Misaligned: go to RESP with bus_error set. No bus cycle is issued.
  - Aligned: next cycle wb_cyc=wb_stb=1. Go to BUS.
- Byte selects: byte = 0001<<address[1:0]; half = 0011<<address[1:0]; word = 1111.
- Write data: byte is replicated to all 4 lanes; half is replicated to both halves; word is passed through.
- BUS:
  - Outputs stay stable until wb_ack.
  - On wb_ack: drop cyc/stb/we/sel the same edge. Capture wb_data_i shifted right by 8*address[1:0]. Mask to size (byte 8b, half 16b), zero-extended. Go to RESP.
  - The counter increments each BUS cycle. When it reaches TIMEOUT_CYCLES-1 without ack: drop the cycle, set bus_error, read_data=0, go to RESP.
  - wb_ack in the same cycle as the timeout wins: normal completion.
- RESP:
  - memory_response=1 for exactly one cycle (delayed one extra cycle if PIPE_RESP=1). bus_error=1 only on error.
  - read_data holds its value until the next read completes. Writes leave read_data unchanged.
  - Go to WAIT_DROP.
- WAIT_DROP: remain until memory_read=memory_write=0, then IDLE. This prevents re-issuing a held request; minimum back-to-back spacing is 1 idle cycle.
- wb_ack outside BUS is ignored.
- Request dropped by the core mid-BUS: the bus cycle completes anyway and the response is still pulsed.
- Latency, aligned access with zero-wait slave (ack in first BUS cycle), PIPE_RESP=0: request seen at edge 0, cyc at edge 1, ack sampled at edge 2, memory_response high after edge 2 → 3 cycles.
- Counter resets on every BUS entry. No wrap: saturates at TIMEOUT_CYCLES-1.

Test Plan:
- Word write addr 0x0000_1004, data 0xDEADBEEF, ack after 2 wait cycles → wb_sel=1111, wb_addr=0x1004, wb_we=1, wb_data_o=0xDEADBEEF; single memory_response, bus_error=0.
- Byte read addr 0x0000_2003, slave returns 0xA1B2C3D4 → wb_sel=1000, wb_addr=0x2000, read_data=0x000000A1.
- Half write addr 0x0000_3002, data 0x0000_5A5A → wb_sel=1100, wb_data_o=0x5A5A5A5A; half read addr 0x3001 → no wb_cyc, memory_response+bus_error pulse next cycle.
- TIMEOUT_CYCLES=8, no ack → wb_cyc high exactly 8 cycles, then drop; memory_response and bus_error both pulse; read_data=0.
- Request held high after response → no second wb_cyc until the request deasserts for ≥1 cycle; then next request proceeds normally.
- Assert reset mid-BUS (cyc high) → wb_cyc/stb and all outputs 0 immediately (asynchronous); late wb_ack after release ignored, no memory_response.
